// File: rtl/conv_nch_acc_pe.sv
// Time-multiplexed multi-channel KxK convolution PE: one channel window per beat,
// CH beats plus bias accumulate into one output pixel, then ReLU / rounding shift / saturate.
module conv_nch_acc_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int K      = 5,
    parameter int CH     = 3,
    parameter int OUT_W  = 8,
    localparam int KK    = K * K,
    localparam int SH_W  = $clog2(ACC_W),
    localparam int CI_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W*KK-1:0] pix_flat,
    input  logic [DATA_W*KK-1:0] wgt_flat,
    input  logic [ACC_W-1:0]     bias,
    input  logic                 cfg_relu,
    input  logic [SH_W-1:0]      cfg_shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [ACC_W-1:0]     out_acc,
    output logic                 out_sat,
    output logic [CI_W-1:0]      ch_idx
);

    localparam logic [CI_W-1:0] CH_LAST = CI_W'(CH - 1);
    localparam logic signed [ACC_W:0] QMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] QMIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    rdy_q;
    logic                    stall;
    logic                    accept;
    logic                    load;
    logic                    s1_vld;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [ACC_W-1:0] psum;
    logic signed [ACC_W-1:0] bias_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] dot;
    logic signed [ACC_W-1:0] sum_nxt;
    logic signed [ACC_W-1:0] prod [KK];

    assign stall    = out_valid & ~out_ready;
    // rdy_q keeps in_ready low while reset is asserted and for the edge it releases on
    assign in_ready = rdy_q & ~stall & ~clear;
    assign accept   = in_valid & in_ready;

    // Per-tap signed products, tap 0 sits in the MSBs of the flat buses
    for (genvar i = 0; i < KK; i++) begin : g_tap
        logic signed [DATA_W-1:0]   p;
        logic signed [DATA_W-1:0]   w;
        logic signed [2*DATA_W-1:0] m;
        assign p       = pix_flat[DATA_W*(KK-i)-1 -: DATA_W];
        assign w       = wgt_flat[DATA_W*(KK-i)-1 -: DATA_W];
        assign m       = p * w;
        assign prod[i] = ACC_W'(m);
    end

    always_comb begin
        dot = '0;
        for (int t = 0; t < KK; t++) dot = dot + prod[t];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    // S1: dot product and group tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            psum     <= '0;
            bias_q   <= '0;
            ch_idx   <= '0;
        end else if (clear) begin
            s1_vld <= 1'b0;
            ch_idx <= '0;
        end else if (!stall) begin
            s1_vld <= accept;
            if (accept) begin
                psum     <= dot;
                s1_first <= (ch_idx == '0);
                s1_last  <= (ch_idx == CH_LAST);
                if (ch_idx == '0) bias_q <= bias;
                ch_idx   <= (ch_idx == CH_LAST) ? '0 : ch_idx + CI_W'(1);
            end
        end
    end

    assign load    = s1_vld & ~stall & ~clear;
    assign sum_nxt = (s1_first ? bias_q : acc) + psum;

    // Quantise the value about to enter the output register
    logic signed [ACC_W:0]  v;
    logic signed [ACC_W:0]  rnd;
    logic signed [ACC_W:0]  vr;
    logic signed [ACC_W:0]  r;
    logic [OUT_W-1:0]       q;
    logic                   q_sat;

    always_comb begin
        v     = (cfg_relu && sum_nxt[ACC_W-1]) ? '0 : {sum_nxt[ACC_W-1], sum_nxt};
        rnd   = '0;
        vr    = v;
        r     = v;
        q     = v[OUT_W-1:0];
        q_sat = 1'b0;
        if (cfg_shift != '0) begin
            rnd = (ACC_W+1)'(1) << (cfg_shift - SH_W'(1));
            vr  = v + rnd;
            r   = vr >>> cfg_shift;
        end
        q = r[OUT_W-1:0];
        if (r > QMAX) begin
            q     = QMAX[OUT_W-1:0];
            q_sat = 1'b1;
        end else if (r < QMIN) begin
            q     = QMIN[OUT_W-1:0];
            q_sat = 1'b1;
        end
    end

    // S2: accumulate, and on the last channel load the held output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (load) acc <= sum_nxt;
            if (load && s1_last) begin
                out_valid <= 1'b1;
                out_acc   <= sum_nxt;
                out_data  <= q;
                out_sat   <= q_sat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
